clock_set_ctrl: RTL and testbench

Timekeeping and time-set controller for the digital clock's hour/minute/second counter chain. It divides the system clock into a 1 Hz seconds tick and debounces the MODE and INC keys. A four-state machine decides whether the chain runs normally or one unit is being set, and emits per-unit select and manual-increment pulses for the counters' manual-set inputs. It also provides a blink strobe for the display of the unit being set.

---
 rtl/clock_set_ctrl.sv | 109 ++++++++++
 tb/tb_clock_set_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz prescaler, MODE/INC key debounce and four-state time-set controller
// driving the select, manual-increment and blink controls of the h/m/s counter chain.
module clock_set_ctrl #(
   parameter int TICK_DIV      = 50000000,
   parameter int DEBOUNCE      = 500000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 10000000,
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic       sec_tick,
   output logic [2:0] set_sel,
   output logic [2:0] manual_pulse,
   output logic       blink,
   output logic [1:0] state
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

   state_t st, st_nx;
   logic [1:0] s1, s2, lvl, lvl_q;
   logic [PW-1:0] pre;
   logic [RW-1:0] rcnt;
   logic [TW-1:0] to;
   logic arm, rep, p_mode, p_inc, in_set, wrap, req, act, fire;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         lvl_q <= '0;
      end else begin
         s1 <= {key_inc, key_mode};
         s2 <= s1;
         lvl_q <= lvl;
      end

   // bit 0 is MODE, bit 1 is INC
   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DW-1:0] cnt;
      logic l;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            cnt <= '0;
            l <= 1'b0;
         end else if (s2[i] == l) cnt <= '0;
         else if (cnt == DW'(DEBOUNCE - 1)) begin
            cnt <= '0;
            l <= ~l;
         end else cnt <= cnt + 1'b1;
      assign lvl[i] = l;
   end

   always_comb begin
      p_mode = lvl[0] & ~lvl_q[0];
      p_inc  = lvl[1] & ~lvl_q[1];
      in_set = st != RUN;
      wrap   = pre == PW'(TICK_DIV - 1);
      req    = arm & lvl[1] & (rcnt == (rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
      act    = p_mode | p_inc | req;
      fire   = in_set & ~p_mode & (p_inc | req) & (manual_pulse == 3'b000);
      st_nx  = p_mode ? state_t'(st + 2'd1)
             : (in_set & wrap & ~act & (to == TW'(TIMEOUT_TICKS - 1))) ? RUN : st;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) st <= RUN;
      else st <= st_nx;

   // pre is the RUN prescaler and, in set states, the blink/timeout phase
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pre <= '0;
         to <= '0;
         rcnt <= '0;
         arm <= 1'b0;
         rep <= 1'b0;
         set_sel <= 3'b000;
         manual_pulse <= 3'b000;
      end else begin
         pre <= (st_nx != st || wrap) ? '0 : pre + 1'b1;
         to <= (st_nx == RUN || act) ? '0 : wrap ? to + 1'b1 : to;
         set_sel <= st_nx == SET_HOUR ? 3'b100 : st_nx == SET_MIN ? 3'b010 : st_nx == SET_SEC ? 3'b001 : 3'b000;
         manual_pulse <= fire ? set_sel : 3'b000;
         if (!in_set || p_mode || !lvl[1]) begin
            arm <= 1'b0;
            rep <= 1'b0;
            rcnt <= '0;
         end else if (p_inc) begin
            arm <= 1'b1;
            rep <= 1'b0;
            rcnt <= RW'(1);
         end else if (req) begin
            rep <= 1'b1;
            rcnt <= RW'(1);
         end else if (arm) rcnt <= rcnt + 1'b1;
      end

   assign sec_tick = (st == RUN) & wrap;
   assign blink = (st == RUN) | (pre < PW'(TICK_DIV / 2));
   assign state = st;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and $urandom key stimulus against a behavioural model built on
// sample windows, time-in-state ages and the repeat schedule arithmetic.
module tb_clock_set_ctrl;
   localparam int TD = 10, DB = 4, RD = 20, RP = 5, TO = 3;

   logic clk = 1'b0, rst = 1'b1, key_mode = 1'b0, key_inc = 1'b0;
   logic sec_tick, blink;
   logic [2:0] set_sel, manual_pulse;
   logic [1:0] state;

   clock_set_ctrl #(.TICK_DIV(TD), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT_TICKS(TO)) dut (
      .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc), .sec_tick(sec_tick),
      .set_sel(set_sel), .manual_pulse(manual_pulse), .blink(blink), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc, mode, age, idle_w, press_cyc, n_pulse, n_tick, n_chg, chg_cyc, ftick, e3;
   bit armed, ms1, ms2, is1, is2, macc, iacc, pm, pi;
   logic [DB-1:0] hm, hi;
   logic [2:0] mp;
   logic [1:0] last_state;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] sel_of(input int m);
      return m == 1 ? 3'b100 : m == 2 ? 3'b010 : m == 3 ? 3'b001 : 3'b000;
   endfunction

   // accepted level flips once the last DB synced samples all disagree with it
   function automatic void deb(input bit s, inout logic [DB-1:0] h, inout bit acc, output bit p);
      h = {h[DB-2:0], s};
      p = 1'b0;
      if (h == {DB{~acc}}) begin
         acc = ~acc;
         p = acc;
      end
   endfunction

   task automatic model_reset();
      cyc = 0; mode = 0; age = 0; idle_w = 0; press_cyc = 0; armed = 0;
      ms1 = 0; ms2 = 0; is1 = 0; is2 = 0; macc = 0; iacc = 0; pm = 0; pi = 0;
      hm = '0; hi = '0; mp = 3'b000; last_state = 2'd0; ftick = -1;
   endtask

   task automatic model_step();
      bit li, req, act, fire, wrap, tout;
      int k, nmode;
      li = iacc;
      k = cyc - press_cyc;
      req = armed && li && (k == RD || (k > RD && (k - RD) % RP == 0));
      act = pm || pi || req;
      fire = mode != 0 && !pm && (pi || req) && mp == 3'b000;
      wrap = mode != 0 && age % TD == TD - 1;
      tout = wrap && !act && idle_w == TO - 1;
      nmode = pm ? (mode + 1) % 4 : tout ? 0 : mode;
      mp = fire ? sel_of(mode) : 3'b000;
      if (mode == 0 || pm || !li) armed = 0;
      else if (pi) begin
         armed = 1;
         press_cyc = cyc;
      end
      idle_w = (nmode == 0 || act) ? 0 : wrap ? idle_w + 1 : idle_w;
      age = nmode != mode ? 0 : age + 1;
      mode = nmode;
      deb(ms2, hm, macc, pm);
      deb(is2, hi, iacc, pi);
      ms2 = ms1; ms1 = key_mode; is2 = is1; is1 = key_inc;
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("state", 32'(state), 32'(mode));
      check("set_sel", 32'(set_sel), 32'(sel_of(mode)));
      check("manual_pulse", 32'(manual_pulse), 32'(mp));
      check("sec_tick", 32'(sec_tick), 32'(mode == 0 && age % TD == TD - 1));
      check("blink", 32'(blink), 32'(mode == 0 || age % TD < TD / 2));
      n_pulse += int'(manual_pulse != 3'b000);
      n_tick += int'(sec_tick);
      if (state != last_state) begin
         chg_cyc = cyc;
         ftick = -1;
         n_chg++;
      end
      if (sec_tick && ftick < 0) ftick = cyc;
      last_state = state;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic press_mode();
      key_mode = 1'b1;
      run(8);
      key_mode = 1'b0;
      run(8);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out", 32'({state, set_sel, manual_pulse, sec_tick, blink}), 32'(10'b00_000_000_0_1));
      rst = 1'b0;
      model_reset();
      n_tick = 0;
      run(100);
      check("idle_ticks", n_tick, 10);

      n_chg = 0;
      key_mode = 1'b1; run(1);
      key_mode = 1'b0; run(1);
      key_mode = 1'b1; run(12);
      key_mode = 1'b0; run(8);
      check("bounce_presses", n_chg, 1);
      check("bounce_state", 32'(state), 1);

      press_mode();
      check("set_min", 32'(state), 2);
      n_pulse = 0;
      key_inc = 1'b1; run(60);
      key_inc = 1'b0; run(10);
      check("hold_pulses_7_to_9", 32'(n_pulse >= 7 && n_pulse <= 9), 1);
      run(40);
      check("timeout_to_run", 32'(state), 0);

      n_pulse = 0; n_tick = 0;
      key_inc = 1'b1; run(60);
      key_inc = 1'b0; run(10);
      check("run_inc_pulses", n_pulse, 0);
      check("run_inc_ticks", n_tick, 7);

      repeat (3) press_mode();
      check("set_sec", 32'(state), 3);
      e3 = chg_cyc;
      n_pulse = 0;
      run(45);
      check("timeout_gap", 32'(chg_cyc - e3), TD * TO);
      check("timeout_pulses", n_pulse, 0);
      check("tick_after_timeout", 32'(ftick - chg_cyc), TD - 1);

      press_mode();
      check("set_hour", 32'(state), 1);
      n_pulse = 0;
      key_mode = 1'b1; key_inc = 1'b1; run(12);
      check("simul_state", 32'(state), 2);
      run(28);
      key_mode = 1'b0; key_inc = 1'b0; run(10);
      check("simul_pulses", n_pulse, 0);

      repeat (150) begin
         key_mode = ($urandom_range(0, 4) == 0);
         key_inc = ($urandom_range(0, 1) == 0);
         run(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40)));
      end

      key_mode = 1'b0; key_inc = 1'b0;
      run(45);
      press_mode();
      key_inc = 1'b1;
      for (int i = 0; i < 30 && mp == 3'b000; i++) step();
      check("inflight_seen", 32'(manual_pulse != 3'b000), 1);
      #2 rst = 1'b1;
      #1 check("async_reset", 32'({state, set_sel, manual_pulse, sec_tick, blink}), 32'(10'b00_000_000_0_1));
      key_inc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
